apb_master: RTL
===============

# apb_master

Single-channel APB requester that turns one-at-a-time host commands into APB SETUP/ACCESS transfers on the peripheral bus. It sits directly upstream of the peripheral APB slaves and drives their psel/penable/pwrite/paddr/pwdata. It returns read data and an error flag to the host through a valid/ready response channel. It adds wait-state support (pready), error passthrough (pslverr) and a wait-state timeout.

## Interface
- ADDR_WIDTH, 8, APB address width
- DATA_WIDTH, 24, APB data width
- TIMEOUT, 16, maximum consecutive ACCESS cycles with pready low before abort (>=2)

- pclk  input  1  bus clock; everything is rising-edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  host command present
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at the edge
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdata  input  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  output  1  response present
- rsp_ready  input  1  host takes response
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and aborts
- rsp_err  output  1  pslverr captured, or timeout abort
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- prdata  input  DATA_WIDTH  APB read data
- pready  input  1  slave ready; tie to 1 for slaves without pready
- pslverr  input  1  slave error; tie to 0 for slaves without pslverr

## Operation
- States: IDLE, SETUP, ACCESS.
- cmd_ready = (state==IDLE) & (!rsp_valid | rsp_ready).
- IDLE:
  - psel=0, penable=0.
  - On acceptance, latch write/addr/wdata and go to SETUP.
  - pwdata is loaded with 0 for reads.
- SETUP:
  - psel=1, penable=0; paddr/pwrite/pwdata come from the latch.
  - Always moves to ACCESS on the next edge; the wait counter is cleared.
- ACCESS:
  - psel=1, penable=1; address, direction and data are unchanged from SETUP.
  - If pready=1:
    - rsp_rdata <= pwrite ? 0 : prdata; rsp_err <= pslverr; rsp_valid <= 1.
    - Go to IDLE.
  - Else if the wait counter equals TIMEOUT-1:
    - Abort: rsp_rdata <= 0, rsp_err <= 1, rsp_valid <= 1.
    - Go to IDLE.
  - Else increment the wait counter.
- Response channel:
  - rsp_valid, rsp_rdata and rsp_err hold until rsp_valid & rsp_ready at an edge; rsp_valid then clears.
  - If a new response is loaded in the same cycle, the new response wins.
  - There is never more than one outstanding command.
- paddr, pwrite and pwdata hold their last values in IDLE and only change on acceptance. There is no toggling between transfers.
- psel is low for at least one cycle between transfers (the IDLE cycle).
- The wait counter is $clog2(TIMEOUT) bits wide, saturates at TIMEOUT-1 and clears in SETUP.

## Timing
- Reset:
  - state IDLE, counter 0.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata and rsp_err are all 0.
  - cmd_ready=1 in the first cycle after reset.
- Reset mid-transfer (SETUP or ACCESS): the transfer is abandoned, psel and penable are 0 after the edge, and no response is produced.
- Reset with a response pending: the response is discarded.
- Zero-wait transfer, command accepted at edge E:
  - SETUP cycle after E.
  - ACCESS cycle after E+1.
  - rsp_valid=1 and psel=0 after E+2.
- Each pready-low cycle adds one cycle of latency.
- Throughput with rsp_ready held high: one transfer every 3 cycles.
- Timeout: rsp_valid rises after the edge that ends the TIMEOUT-th ACCESS cycle with pready low.
- A late pready arriving after the abort is ignored.
- If pready=1 arrives in the final (TIMEOUT-th) ACCESS cycle, it wins over the timeout and the normal response is returned.
- Host stall: while rsp_valid=1 & rsp_ready=0, cmd_ready=0 and the APB bus stays idle.

## Test plan
- Write 0x5A, data 0xABCDEF, pready=1:
  - psel=1/penable=0 one cycle, then 1/1 one cycle, with paddr=0x5A, pwrite=1, pwdata=0xABCDEF.
  - Response rdata=0, err=0, 3 cycles after acceptance.
- Read 0x10 with prdata=0x123456 and pready=1: response rdata=0x123456, err=0; pwdata=0 during the transfer.
- Read with pready low for 3 ACCESS cycles, then high with pslverr=1: ACCESS lasts 4 cycles with signals stable; response err=1, rdata=prdata.
- pready held 0 with TIMEOUT=16: exactly 16 ACCESS cycles, then psel=0 and response rdata=0, err=1; raising pready afterwards has no effect.
- Back-to-back: cmd_valid and rsp_ready held 1 for 4 commands gives 4 transfers, each 3 cycles, with psel low one cycle between them. With rsp_ready=0 after the first response, cmd_ready stays 0 and no second SETUP occurs until rsp_ready=1.
- Reset asserted during ACCESS of a read: psel, penable and rsp_valid are 0 after the edge, no response ever appears, and the next command runs normally.

Source files
------------

// File: rtl/apb_master.sv
// Single-channel APB requester: one host command at a time becomes an APB SETUP/ACCESS
// transfer, with pready wait states, pslverr passthrough and a wait-state timeout abort.
module apb_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 24,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    // A new command is only taken once any pending response has been (or is being) consumed.
    assign cmd_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
    assign psel      = (state_q != IDLE);
    assign penable   = (state_q == ACCESS);
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                // A pready in the last permitted cycle still completes normally.
                if (pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
